// File: rtl/apb_slave_mem.sv
// APB completer with a word-indexed register memory, programmable wait states
// and a saturating count of errored transfers.
module apb_slave_mem #(
  parameter int unsigned ADDR_WIDTH  = 8,
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned DEPTH       = 16,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic                  pclk,
  input  logic                  preset_n,
  input  logic                  pselx,
  input  logic                  penable,
  input  logic                  pwrite,
  input  logic [ADDR_WIDTH-1:0] paddr,
  input  logic [DATA_WIDTH-1:0] pwdata,
  output logic                  pready,
  output logic                  pslverr,
  output logic [DATA_WIDTH-1:0] prdata,
  output logic [7:0]            err_cnt_o
);

  localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t                state, state_next;
  logic [IDX_W-1:0]      addr_q;
  logic                  write_q;
  logic                  err_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [3:0]            cnt;
  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic                  setup;
  logic                  addr_err;
  logic [IDX_W-1:0]      resp_idx;
  logic                  resp_err;
  logic                  resp_read;

  assign setup    = pselx & ~penable;
  assign addr_err = 32'(paddr) >= 32'(DEPTH);

  // With zero wait states RESP is entered straight from the setup edge, so the
  // response must be built from the live bus rather than the latched copy.
  assign resp_idx  = (state == S_IDLE) ? paddr[IDX_W-1:0] : addr_q;
  assign resp_err  = (state == S_IDLE) ? addr_err         : err_q;
  assign resp_read = (state == S_IDLE) ? ~pwrite          : ~write_q;

  always_ff @(posedge pclk or negedge preset_n) begin
    if (!preset_n) state <= S_IDLE;
    else           state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: if (setup) state_next = (WAIT_CYCLES == 0) ? S_RESP : S_WAIT;
      S_WAIT: begin
        if (!pselx)          state_next = S_IDLE;
        else if (cnt == 4'd1) state_next = S_RESP;
      end
      S_RESP:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge pclk or negedge preset_n) begin
    if (!preset_n) begin
      addr_q    <= '0;
      write_q   <= 1'b0;
      err_q     <= 1'b0;
      wdata_q   <= '0;
      cnt       <= '0;
      pready    <= 1'b0;
      pslverr   <= 1'b0;
      prdata    <= '0;
      err_cnt_o <= '0;
    end else begin
      if (state == S_IDLE && setup) begin
        addr_q  <= paddr[IDX_W-1:0];
        write_q <= pwrite;
        wdata_q <= pwdata;
        err_q   <= addr_err;
        cnt     <= 4'(WAIT_CYCLES);
      end else if (state == S_WAIT) begin
        cnt <= cnt - 4'd1;
      end

      if (state == S_RESP && err_q && err_cnt_o != 8'hFF)
        err_cnt_o <= err_cnt_o + 8'd1;

      // RESP lasts exactly one cycle, so entering it is a one-cycle pulse.
      if (state_next == S_RESP) begin
        pready  <= 1'b1;
        pslverr <= resp_err;
        prdata  <= (resp_read && !resp_err) ? mem[resp_idx] : '0;
      end else begin
        pready  <= 1'b0;
        pslverr <= 1'b0;
        prdata  <= '0;
      end
    end
  end

  always_ff @(posedge pclk or negedge preset_n) begin
    if (!preset_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (state == S_RESP && write_q && !err_q) begin
      mem[addr_q] <= wdata_q;
    end
  end

endmodule

// File: tb/tb_apb_slave_mem.sv
// Directed bench for apb_slave_mem: a 2-wait-state instance and a 0-wait-state
// instance share one APB bus; each transfer watches the selected instance.
module tb_apb_slave_mem;

  logic        pclk = 1'b0;
  logic        preset_n;
  logic        pselx, penable, pwrite;
  logic [7:0]  paddr;
  logic [31:0] pwdata;

  logic        pready2, pslverr2, pready0, pslverr0;
  logic [31:0] prdata2, prdata0;
  logic [7:0]  err_cnt2, err_cnt0;

  int checks   = 0;
  int failures = 0;

  always #5 pclk = ~pclk;

  apb_slave_mem #(.ADDR_WIDTH(8), .DATA_WIDTH(32), .DEPTH(16), .WAIT_CYCLES(2)) dut2 (
    .pclk(pclk), .preset_n(preset_n), .pselx(pselx), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata), .pready(pready2), .pslverr(pslverr2),
    .prdata(prdata2), .err_cnt_o(err_cnt2)
  );

  apb_slave_mem #(.ADDR_WIDTH(8), .DATA_WIDTH(32), .DEPTH(16), .WAIT_CYCLES(0)) dut0 (
    .pclk(pclk), .preset_n(preset_n), .pselx(pselx), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata), .pready(pready0), .pslverr(pslverr0),
    .prdata(prdata0), .err_cnt_o(err_cnt0)
  );

  task automatic tick();
    @(posedge pclk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One APB transfer; returns the access cycles seen with pready low.
  task automatic xfer(input bit zero_wait, input bit wr, input logic [7:0] a,
                      input logic [31:0] d, output logic [31:0] rd,
                      output logic err, output int waits);
    logic rdy;
    pselx = 1'b1; penable = 1'b0; pwrite = wr; paddr = a; pwdata = d;
    tick();
    penable = 1'b1;
    waits = 0;
    rd = 'x;
    err = 1'bx;
    for (int i = 0; i < 20; i++) begin
      rdy = zero_wait ? pready0 : pready2;
      if (rdy) begin
        rd  = zero_wait ? prdata0 : prdata2;
        err = zero_wait ? pslverr0 : pslverr2;
        break;
      end
      waits++;
      tick();
    end
    if (waits >= 20) check("pready_timeout", 32'(waits), 32'd0);
    tick();
  endtask

  task automatic idle();
    pselx = 1'b0; penable = 1'b0;
    tick();
  endtask

  logic [31:0] rd;
  logic        err;
  int          waits;
  int          bad;

  initial begin
    preset_n = 1'b0;
    pselx = 1'b0; penable = 1'b0; pwrite = 1'b0; paddr = '0; pwdata = '0;
    repeat (3) tick();
    check("rst_pready",  32'(pready2),  32'd0);
    check("rst_pslverr", 32'(pslverr2), 32'd0);
    check("rst_prdata",  prdata2,       32'd0);
    check("rst_err_cnt", 32'(err_cnt2), 32'd0);
    preset_n = 1'b1;
    tick();

    // Write then read word 3
    xfer(0, 1, 8'd3, 32'hDEADBEEF, rd, err, waits);
    check("wr3_waits", 32'(waits), 32'd2);
    check("wr3_err",   32'(err),   32'd0);
    check("wr3_pready_after", 32'(pready2), 32'd0);
    idle();
    xfer(0, 0, 8'd3, 32'h0, rd, err, waits);
    check("rd3_waits", 32'(waits), 32'd2);
    check("rd3_data",  rd,         32'hDEADBEEF);
    check("rd3_err",   32'(err),   32'd0);
    check("rd3_prdata_after", prdata2, 32'd0);
    idle();

    // Out-of-range accesses
    xfer(0, 0, 8'd20, 32'h0, rd, err, waits);
    check("rd20_waits", 32'(waits), 32'd2);
    check("rd20_err",   32'(err),   32'd1);
    check("rd20_data",  rd,         32'd0);
    check("rd20_cnt",   32'(err_cnt2), 32'd1);
    check("rd20_pslverr_after", 32'(pslverr2), 32'd0);
    xfer(0, 1, 8'd20, 32'h12345678, rd, err, waits);
    check("wr20_err", 32'(err),       32'd1);
    check("wr20_cnt", 32'(err_cnt2),  32'd2);
    xfer(0, 0, 8'd4, 32'h0, rd, err, waits);
    check("rd4_data", rd,       32'd0);
    check("rd4_err",  32'(err), 32'd0);
    idle();

    // Back-to-back write/read of word 5
    xfer(0, 1, 8'd5, 32'h1, rd, err, waits);
    xfer(0, 0, 8'd5, 32'h0, rd, err, waits);
    check("b2b_waits", 32'(waits), 32'd2);
    check("b2b_data",  rd,         32'h1);
    idle();

    // Abort a write to 7 by dropping pselx during WAIT
    pselx = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 8'd7; pwdata = 32'hA5;
    tick();
    penable = 1'b1;
    tick();
    check("abort_pready_w", 32'(pready2), 32'd0);
    pselx = 1'b0; penable = 1'b0;
    tick();
    check("abort_pready_1", 32'(pready2), 32'd0);
    tick();
    check("abort_pready_2", 32'(pready2), 32'd0);
    xfer(0, 0, 8'd7, 32'h0, rd, err, waits);
    check("abort_rd7",  rd,             32'd0);
    check("abort_cnt",  32'(err_cnt2),  32'd2);
    idle();

    // Reset during WAIT of a write to 2
    pselx = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 8'd2; pwdata = 32'h77;
    tick();
    penable = 1'b1;
    tick();
    #2 preset_n = 1'b0;
    #1;
    check("mid_rst_pready",  32'(pready2),  32'd0);
    check("mid_rst_pslverr", 32'(pslverr2), 32'd0);
    check("mid_rst_prdata",  prdata2,       32'd0);
    check("mid_rst_cnt",     32'(err_cnt2), 32'd0);
    pselx = 1'b0; penable = 1'b0;
    tick();
    preset_n = 1'b1;
    tick();
    xfer(0, 0, 8'd2, 32'h0, rd, err, waits);
    check("post_rst_rd2", rd, 32'd0);
    xfer(0, 0, 8'd3, 32'h0, rd, err, waits);
    check("post_rst_rd3", rd, 32'd0);
    idle();

    // Zero-wait instance
    xfer(1, 1, 8'd6, 32'hCAFEF00D, rd, err, waits);
    check("wc0_wr_waits", 32'(waits), 32'd0);
    xfer(1, 0, 8'd6, 32'h0, rd, err, waits);
    check("wc0_rd_waits", 32'(waits), 32'd0);
    check("wc0_rd_data",  rd,         32'hCAFEF00D);
    idle();
    bad = 0;
    for (int i = 0; i < 300; i++) begin
      xfer(1, 0, 8'd200, 32'h0, rd, err, waits);
      if (waits != 0 || err !== 1'b1 || rd !== 32'd0) bad++;
      if (i == 0)   check("wc0_cnt_1",   32'(err_cnt0), 32'd1);
      if (i == 254) check("wc0_cnt_255", 32'(err_cnt0), 32'd255);
    end
    idle();
    check("wc0_err_resp", 32'(bad),      32'd0);
    check("wc0_cnt_sat",  32'(err_cnt0), 32'd255);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
